// File: rtl/instr_fetch_unit.sv
// Fetch stage of the riscv32i multicycle core: owns PC/OldPC, runs one valid/ack read per FetchStart.
// Optional watchdog on the memory wait is enabled with `define FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FetchStart,
  input  logic        PCWrite,
  input  logic [31:0] PCNext,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemRdata,
  input  logic        MemAck,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] OldPC,
  output logic        FetchDone,
  output logic        Busy,
  output logic        MisalignErr,
  output logic        FetchTimeout
);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] old_pc_q;
  logic [31:0] instr_q;
  logic        mem_req_q;
  logic        fetch_done_q;
  logic        misalign_q;
  logic        redir_pend_q;
  logic [31:0] redir_tgt_q;

  logic [31:0] fetch_pc_d;
  logic [31:0] leave_pc_d;
  logic [31:0] seq_pc_d;
  logic        expire_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;
`endif

  // Effective fetch address in IDLE and the PC taken when leaving REQ (redirect beats sequential)
  always_comb begin
    fetch_pc_d = pc_q;
    leave_pc_d = pc_q;
    seq_pc_d   = pc_q + 32'd4;
    expire_d   = 1'b0;
    if (PCWrite) begin
      fetch_pc_d = PCNext;
    end else begin
      fetch_pc_d = pc_q;
    end
    if (PCWrite) begin
      leave_pc_d = PCNext;
      seq_pc_d   = PCNext;
    end else if (redir_pend_q) begin
      leave_pc_d = redir_tgt_q;
      seq_pc_d   = redir_tgt_q;
    end else begin
      leave_pc_d = pc_q;
      seq_pc_d   = pc_q + 32'd4;
    end
`ifdef FETCH_TIMEOUT_EN
    expire_d = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    expire_d = 1'b0;
`endif
  end

  // Fetch FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      old_pc_q     <= RESET_PC;
      instr_q      <= NOP_INSTR;
      mem_req_q    <= 1'b0;
      fetch_done_q <= 1'b0;
      misalign_q   <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= RESET_PC;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      fetch_done_q <= 1'b0;
      misalign_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          pc_q <= fetch_pc_d;
          if (FetchStart && (fetch_pc_d[1:0] == 2'b00)) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end else if (FetchStart) begin
            misalign_q <= 1'b1;
          end else begin
            mem_req_q <= 1'b0;
          end
        end
        REQ: begin
          if (MemAck) begin
            instr_q      <= MemRdata;
            old_pc_q     <= pc_q;
            pc_q         <= seq_pc_d;
            fetch_done_q <= 1'b1;
            redir_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            state_q      <= IDLE;
          end else if (expire_d) begin
            pc_q         <= leave_pc_d;
            redir_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            state_q      <= IDLE;
`ifdef FETCH_TIMEOUT_EN
            timeout_q    <= 1'b1;
`endif
          end else begin
            if (PCWrite) begin
              redir_tgt_q  <= PCNext;
              redir_pend_q <= 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign MemReq      = mem_req_q;
  assign MemAddr     = pc_q;
  assign Instr       = instr_q;
  assign PC          = pc_q;
  assign OldPC       = old_pc_q;
  assign FetchDone   = fetch_done_q;
  assign Busy        = (state_q == REQ);
  assign MisalignErr = misalign_q;
`ifdef FETCH_TIMEOUT_EN
  assign FetchTimeout = timeout_q;
`else
  assign FetchTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Table-driven bench for instr_fetch_unit with a scoreboard of expected fetch results.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, FetchStart, PCWrite, MemAck;
  logic [31:0] PCNext, MemRdata;
  logic        MemReq, FetchDone, Busy, MisalignErr, FetchTimeout;
  logic [31:0] MemAddr, Instr, PC, OldPC;

  int checks = 0;
  int failures = 0;
  int to_pulses = 0;

  typedef struct {
    logic        mis;
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        pre_wr;
    logic [31:0] pre_pc;
    int          ack_dly;
    logic [31:0] rdata;
    logic        req_wr;
    logic [31:0] req_tgt;
    logic [31:0] exp_addr;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .FetchStart(FetchStart), .PCWrite(PCWrite), .PCNext(PCNext),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemRdata(MemRdata), .MemAck(MemAck),
    .Instr(Instr), .PC(PC), .OldPC(OldPC), .FetchDone(FetchDone), .Busy(Busy),
    .MisalignErr(MisalignErr), .FetchTimeout(FetchTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every FetchDone / MisalignErr pulse pops one expected result
  always @(negedge clk) begin
    if (FetchTimeout) to_pulses++;
    if (FetchDone || MisalignErr) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, FetchDone, MisalignErr}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, FetchDone, MisalignErr}, e.mis ? 32'd1 : 32'd2);
        chk("sb_instr", Instr, e.instr);
        chk("sb_oldpc", OldPC, e.old_pc);
        chk("sb_pc", PC, e.pc);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    if (v.pre_wr) begin
      PCWrite = 1'b1; PCNext = v.pre_pc;
      tick();
      PCWrite = 1'b0;
      chk("idle_redirect", PC, v.pre_pc);
    end
    FetchStart = 1'b1;
    sb.push_back(v.e);
    tick();
    FetchStart = 1'b0;
    chk("addr", MemAddr, v.exp_addr);
    if (v.e.mis) begin
      chk("mis_memreq", {31'd0, MemReq}, 32'd0);
      chk("mis_busy", {31'd0, Busy}, 32'd0);
      tick();
      chk("mis_pulse_end", {31'd0, MisalignErr}, 32'd0);
    end else begin
      chk("memreq", {31'd0, MemReq}, 32'd1);
      for (int i = 0; i < v.ack_dly; i++) begin
        if (i == 0 && v.req_wr) begin
          PCWrite = 1'b1; PCNext = v.req_tgt;
        end
        FetchStart = 1'b1;
        tick();
        PCWrite = 1'b0; FetchStart = 1'b0;
        chk("req_hold", {31'd0, MemReq}, 32'd1);
        chk("addr_stable", MemAddr, v.exp_addr);
      end
      MemAck = 1'b1; MemRdata = v.rdata;
      tick();
      MemAck = 1'b0; MemRdata = 32'hBAD0_0000;
      chk("done_memreq_low", {31'd0, MemReq}, 32'd0);
      chk("done_busy_low", {31'd0, Busy}, 32'd0);
      tick();
      chk("done_pulse_end", {31'd0, FetchDone}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0, 2, 32'h0050_0093, 1'b0, 32'h0, 32'h0000_0000,
                '{1'b0, 32'h0050_0093, 32'h0000_0000, 32'h0000_0004}};
    vecs[1] = '{1'b1, 32'h100, 0, 32'h00A0_0113, 1'b0, 32'h0, 32'h0000_0100,
                '{1'b0, 32'h00A0_0113, 32'h0000_0100, 32'h0000_0104}};
    vecs[2] = '{1'b0, 32'h0, 3, 32'h0000_0517, 1'b1, 32'h200, 32'h0000_0104,
                '{1'b0, 32'h0000_0517, 32'h0000_0104, 32'h0000_0200}};
    vecs[3] = '{1'b1, 32'h102, 0, 32'h0, 1'b0, 32'h0, 32'h0000_0102,
                '{1'b1, 32'h0000_0517, 32'h0000_0104, 32'h0000_0102}};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'hFFFF_FFFC,
                '{1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0000_0000}};
    vecs[5] = '{1'b0, 32'h0, 1, 32'h1234_5678, 1'b0, 32'h0, 32'h0000_0000,
                '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0004}};

    reset = 1'b1; FetchStart = 1'b0; PCWrite = 1'b0; PCNext = 32'h0;
    MemAck = 1'b0; MemRdata = 32'hBAD0_0000;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pc", PC, 32'h0);
    chk("rst_oldpc", OldPC, 32'h0);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_flags", {28'd0, MemReq, FetchDone, MisalignErr, Busy}, 32'd0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // reset during an outstanding request
    FetchStart = 1'b1; tick(); FetchStart = 1'b0;
    chk("pre_rst_memreq", {31'd0, MemReq}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_memreq", {31'd0, MemReq}, 32'd0);
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_instr", Instr, 32'h0000_0013);
    chk("midrst_busy", {31'd0, Busy}, 32'd0);

    // two redirects during REQ: last one wins
    FetchStart = 1'b1; tick(); FetchStart = 1'b0;
    PCWrite = 1'b1; PCNext = 32'h200; tick();
    PCNext = 32'h300; tick(); PCWrite = 1'b0;
    chk("req_pc_hold", PC, 32'h0);
    sb.push_back('{1'b0, 32'hCAFE_0013, 32'h0, 32'h300});
    MemAck = 1'b1; MemRdata = 32'hCAFE_0013; tick(); MemAck = 1'b0;
    tick();

    // redirect in the ack cycle overrides the pending one
    FetchStart = 1'b1; tick(); FetchStart = 1'b0;
    PCWrite = 1'b1; PCNext = 32'h400; tick();
    PCNext = 32'h500; MemAck = 1'b1; MemRdata = 32'h0000_0293;
    sb.push_back('{1'b0, 32'h0000_0293, 32'h300, 32'h500});
    tick(); PCWrite = 1'b0; MemAck = 1'b0;
    tick();

    // ack while idle is ignored
    MemAck = 1'b1; MemRdata = 32'hFFFF_FFFF; tick(); MemAck = 1'b0;
    chk("idle_ack_done", {31'd0, FetchDone}, 32'd0);
    chk("idle_ack_instr", Instr, 32'h0000_0293);
    chk("idle_ack_pc", PC, 32'h500);

`ifdef FETCH_TIMEOUT_EN
    FetchStart = 1'b1; tick(); FetchStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_req", {30'd0, MemReq, FetchTimeout}, 32'd2);
    end
    tick();
    chk("to_pulse", {30'd0, MemReq, FetchTimeout}, 32'd1);
    chk("to_pc", PC, 32'h500);
    chk("to_instr", Instr, 32'h0000_0293);
    tick();
    chk("to_pulse_end", {31'd0, FetchTimeout}, 32'd0);
    FetchStart = 1'b1; tick(); FetchStart = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    MemAck = 1'b1; MemRdata = 32'h0010_0073;
    sb.push_back('{1'b0, 32'h0010_0073, 32'h500, 32'h504});
    tick(); MemAck = 1'b0;
    chk("to_ack_wins", {30'd0, FetchDone, FetchTimeout}, 32'd2);
    tick();
    chk("to_pulse_count", to_pulses, 32'd1);
`else
    chk("no_timeout", to_pulses, 32'd0);
`endif

    tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
